// File: rtl/sl_core_mem_responder.sv
// Memory-side responder for the core request interface: one request at a time, word-wide RAM,
// ack after LATENCY cycles (plus 0..3 LFSR-driven extra cycles when SL_CORE_MEM_RANDOM_LAT_EN).
module sl_core_mem_responder #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 2
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
  , parameter logic [3:0] LFSR_SEED = 4'hA
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  input  logic [2:0]  req_cop,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ack,
  output logic [31:0] req_ack_data,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on an IDLE posedge with req_val=1; its fields are latched
  // there, so the requester may change them once req_ack has been seen high for one cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

  localparam logic [2:0] COP_READ  = 3'b000;
  localparam logic [2:0] COP_WRITE = 3'b001;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          cop_q, cop_d;
  logic [2:0]          size_q, size_d;
  logic [MEM_AW+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [31:0]         ack_data_q, ack_data_d;
  logic [4:0]          lat_load;
  logic                mem_we;
  logic [31:0]         rd_word, wr_word, rd_data;
  logic [MEM_AW-1:0]   idx;
  logic                unused_addr_hi;

  logic [31:0] mem_q [2**MEM_AW];

  // Upper address bits are ignored so the memory wraps.
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];
  assign idx            = addr_q[MEM_AW+1:2];
  assign rd_word        = mem_q[idx];

`ifdef SL_CORE_MEM_RANDOM_LAT_EN
  logic [3:0] lfsr_q, lfsr_d;
  assign lat_load = 5'(LATENCY - 1) + {3'b000, lfsr_q[1:0]};
`else
  assign lat_load = 5'(LATENCY - 1);
`endif

  // Lane merge for writes and right-aligned zero-extended extraction for reads.
  always_comb begin
    wr_word = rd_word;
    rd_data = rd_word;
    if (size_q == 3'd0) begin
      wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      rd_data = {24'h0, rd_word[{addr_q[1:0], 3'b000} +: 8]};
    end else if (size_q == 3'd1) begin
      wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      rd_data = {16'h0, rd_word[{addr_q[1], 4'b0000} +: 16]};
    end else begin
      wr_word = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cop_d      = cop_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = 1'b0;
    ack_data_d = 32'h0;
    mem_we     = 1'b0;
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          cop_d   = req_cop;
          size_d  = req_size;
          addr_d  = req_addr[MEM_AW+1:0];
          wdata_d = req_wdata;
          cnt_d   = lat_load;
          state_d = (lat_load == 5'd0) ? S_ACK : S_WAIT;
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
          lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
        ack_d   = 1'b1;
        if (cop_q == COP_READ)  ack_data_d = rd_data;
        if (cop_q == COP_WRITE) mem_we     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      cop_q      <= 3'd0;
      size_q     <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      ack_q      <= 1'b0;
      ack_data_q <= 32'h0;
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
      lfsr_q     <= LFSR_SEED;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cop_q      <= cop_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      ack_data_q <= ack_data_d;
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  // Contents are deliberately not reset; a write lost to reset never reaches here.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  assign req_ack      = ack_q;
  assign req_ack_data = ack_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sl_core_mem_responder.sv
// Directed bench for sl_core_mem_responder: a LATENCY=2 instance for most traffic and a
// LATENCY=1 instance for back-to-back requests.
module tb_sl_core_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v2 = 1'b0, v1 = 1'b0;
  logic [2:0]  c2 = '0, c1 = '0, s2 = '0, s1 = '0;
  logic [31:0] a2 = '0, a1 = '0, w2 = '0, w1 = '0;
  logic        ack2, ack1;
  logic [31:0] ad2, ad1;
  logic [1:0]  st2, st1;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  sl_core_mem_responder #(.MEM_AW(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_val(v2), .req_cop(c2), .req_size(s2), .req_addr(a2),
    .req_wdata(w2), .req_ack(ack2), .req_ack_data(ad2), .dbg_state(st2));

  sl_core_mem_responder #(.MEM_AW(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_val(v1), .req_cop(c1), .req_size(s1), .req_addr(a1),
    .req_wdata(w1), .req_ack(ack1), .req_ack_data(ad1), .dbg_state(st1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue one request on the selected instance; returns ack data and edges from sample to ack.
  task automatic do_req(input bit sel, input logic [2:0] cop, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] data, output int lat);
    @(posedge clk); #1;
    if (sel) begin v1 = 1'b1; c1 = cop; s1 = size; a1 = addr; w1 = wdata; end
    else     begin v2 = 1'b1; c2 = cop; s2 = size; a2 = addr; w2 = wdata; end
    @(posedge clk);
    lat  = 0;
    data = 32'h0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? ack1 : ack2) begin
        data = sel ? ad1 : ad2;
        break;
      end
    end
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic xact(input string tag, input bit sel, input logic [2:0] cop,
                      input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp);
    logic [31:0] data;
    int          lat;
    int          base;
    base = sel ? 1 : 2;
    do_req(sel, cop, size, addr, wdata, data, lat);
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
    chk({tag, "_lat"}, 32'((lat >= base) && (lat <= base + 3)), 32'd1);
`else
    chk({tag, "_lat"}, 32'(lat), 32'(base));
`endif
    chk({tag, "_data"}, data, exp);
    @(posedge clk); #1;
    chk({tag, "_ack_low"}, {31'h0, sel ? ack1 : ack2}, 32'h0);
    chk({tag, "_data_low"}, sel ? ad1 : ad2, 32'h0);
  endtask

  initial begin
    logic prev;
    int   nreq;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack2", {31'h0, ack2}, 32'h0);
    chk("rst_data2", ad2, 32'h0);
    chk("rst_state2", {30'h0, st2}, 32'h0);
    chk("rst_ack1", {31'h0, ack1}, 32'h0);
    rst = 1'b0;

    // Word write / read
    xact("wr_word", 1'b0, 3'b001, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0);
    xact("rd_word", 1'b0, 3'b000, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF);

    // Byte lanes and force-aligned halves
    xact("wr_byte", 1'b0, 3'b001, 3'd0, 32'h13, 32'hFFFFFF55, 32'h0);
    xact("rd_word2", 1'b0, 3'b000, 3'd2, 32'h10, 32'h0, 32'h55ADBEEF);
    xact("rd_half", 1'b0, 3'b000, 3'd1, 32'h12, 32'h0, 32'h000055AD);
    xact("rd_half_mis", 1'b0, 3'b000, 3'd1, 32'h13, 32'h0, 32'h000055AD);
    xact("rd_byte", 1'b0, 3'b000, 3'd0, 32'h11, 32'h0, 32'h000000BE);
    xact("rd_size7", 1'b0, 3'b000, 3'd7, 32'h13, 32'h0, 32'h55ADBEEF);

    // Address wrap
    xact("rd_wrap", 1'b0, 3'b000, 3'd2, (32'd4 << 10) + 32'h10, 32'h0, 32'h55ADBEEF);

    // Reset during WAIT drops the pending write
    xact("wr_old", 1'b0, 3'b001, 3'd2, 32'h20, 32'hA5A5A5A5, 32'h0);
    @(posedge clk); #1;
    v2 = 1'b1; c2 = 3'b001; s2 = 3'd2; a2 = 32'h20; w2 = 32'h12345678;
    @(posedge clk); #1;
    chk("mid_state_wait", {30'h0, st2}, 32'h1);
    rst = 1'b1;
    v2  = 1'b0;
    #1;
    chk("mid_rst_state", {30'h0, st2}, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_ack", {31'h0, ack2}, 32'h0);
    end
    rst = 1'b0;
    xact("rd_after_rst", 1'b0, 3'b000, 3'd2, 32'h20, 32'h0, 32'hA5A5A5A5);
    xact("rd_kept", 1'b0, 3'b000, 3'd2, 32'h10, 32'h0, 32'h55ADBEEF);

    // NOP opcode
    xact("nop", 1'b0, 3'b101, 3'd2, 32'h10, 32'h0BADF00D, 32'h0);
    xact("rd_after_nop", 1'b0, 3'b000, 3'd2, 32'h10, 32'h0, 32'h55ADBEEF);

    // Back-to-back on LATENCY=1: val held, new fields after each ack
    @(posedge clk); #1;
    v1 = 1'b1; c1 = 3'b001; s1 = 3'd2; a1 = 32'h40; w1 = 32'h1000;
    nreq = 0;
    prev = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
`ifdef SL_CORE_MEM_RANDOM_LAT_EN
      chk("b2b_no_consec", {31'h0, prev & ack1}, 32'h0);
`else
      if (k < 9) chk("b2b_pattern", {31'h0, ack1}, {31'h0, (k % 2) == 1});
`endif
      prev = ack1;
      if (ack1) begin
        nreq++;
        a1 = 32'h40 + 32'(4 * nreq);
        w1 = 32'h1000 + 32'(nreq);
        if (nreq == 4) v1 = 1'b0;
      end
    end
    v1 = 1'b0;
    chk("b2b_count", 32'(nreq), 32'd4);
    xact("b2b_rd_last", 1'b1, 3'b000, 3'd2, 32'h4C, 32'h0, 32'h00001003);
    xact("b2b_rd_first", 1'b1, 3'b000, 3'd2, 32'h40, 32'h0, 32'h00001000);

`ifdef SL_CORE_MEM_RANDOM_LAT_EN
    for (int i = 0; i < 16; i++) begin
      xact("rand_nop", 1'b0, 3'b111, 3'd2, 32'($urandom_range(0, 1023)) << 2, 32'h0, 32'h0);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

endmodule
